// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions: state encodings, opcodes, ALU select codes and
// datapath strobe bit positions used by the sequencer and the datapath.
package cpu_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_RST  = 4'd0,
      ST_T0   = 4'd7,
      ST_T1   = 4'd8,
      ST_T2   = 4'd9,
      ST_T3   = 4'd10,
      ST_T4   = 4'd11,
      ST_T5   = 4'd12,
      ST_HALT = 4'd15
   } state_t;

   typedef enum logic [1:0] {
      OPC_NOP  = 2'd0,
      OPC_ALU  = 2'd1,
      OPC_HALT = 2'd2
   } op_class_t;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam logic [3:0] ALU_NONE = 4'd0;
   localparam logic [3:0] ALU_ADD  = 4'd1;
   localparam logic [3:0] ALU_SUB  = 4'd2;
   localparam logic [3:0] ALU_AND  = 4'd3;
   localparam logic [3:0] ALU_OR   = 4'd4;

   localparam int CTRL_PCOUT   = 0;
   localparam int CTRL_ZLOWOUT = 1;
   localparam int CTRL_MDROUT  = 2;
   localparam int CTRL_MARIN   = 3;
   localparam int CTRL_ZIN     = 4;
   localparam int CTRL_PCIN    = 5;
   localparam int CTRL_MDRIN   = 6;
   localparam int CTRL_IRIN    = 7;
   localparam int CTRL_YIN     = 8;
   localparam int CTRL_INCPC   = 9;
   localparam int CTRL_READ    = 10;
   localparam int CTRL_GRA     = 11;
   localparam int CTRL_GRB     = 12;
   localparam int CTRL_GRC     = 13;
   localparam int CTRL_RIN     = 14;
   localparam int CTRL_ROUT    = 15;

   localparam logic [15:0] CTRL_T0 = (16'd1 << CTRL_PCOUT) | (16'd1 << CTRL_MARIN)
                                   | (16'd1 << CTRL_INCPC) | (16'd1 << CTRL_ZIN);
   localparam logic [15:0] CTRL_T1 = (16'd1 << CTRL_ZLOWOUT) | (16'd1 << CTRL_PCIN)
                                   | (16'd1 << CTRL_READ) | (16'd1 << CTRL_MDRIN);
   localparam logic [15:0] CTRL_T2 = (16'd1 << CTRL_MDROUT) | (16'd1 << CTRL_IRIN);
   localparam logic [15:0] CTRL_T3 = (16'd1 << CTRL_GRB) | (16'd1 << CTRL_ROUT)
                                   | (16'd1 << CTRL_YIN);
   localparam logic [15:0] CTRL_T4 = (16'd1 << CTRL_GRC) | (16'd1 << CTRL_ROUT)
                                   | (16'd1 << CTRL_ZIN);
   localparam logic [15:0] CTRL_T5 = (16'd1 << CTRL_ZLOWOUT) | (16'd1 << CTRL_GRA)
                                   | (16'd1 << CTRL_RIN);

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode classifier: IR[31:27] -> instruction class and ALU select.
module opcode_decoder
   import cpu_ctrl_pkg::*;
(
   input  logic [4:0] i_opcode,
   output op_class_t  o_op_class,
   output logic [3:0] o_alu_op
);

   always_comb begin
      o_op_class = OPC_NOP;
      o_alu_op   = ALU_NONE;
      case (i_opcode)
         OP_ADD:  begin o_op_class = OPC_ALU; o_alu_op = ALU_ADD; end
         OP_SUB:  begin o_op_class = OPC_ALU; o_alu_op = ALU_SUB; end
         OP_AND:  begin o_op_class = OPC_ALU; o_alu_op = ALU_AND; end
         OP_OR:   begin o_op_class = OPC_ALU; o_alu_op = ALU_OR;  end
         OP_HALT: o_op_class = OPC_HALT;
         default: ;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute control sequencer driving the datapath strobes.
// Optional feature: define CS_MEM_WAIT_EN to stretch T1 until mem_ready.
module control_sequencer
   import cpu_ctrl_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] IR,
   input  logic        Stop,
`ifdef CS_MEM_WAIT_EN
   input  logic        mem_ready,
`endif
   output logic [15:0] ctrl,
   output logic [3:0]  alu_op,
   output logic        Run,
   output logic [3:0]  state
);

   state_t     r_state;
   op_class_t  w_op_class;
   logic [3:0] w_dec_alu_op;
   logic       w_t1_done;
   logic       w_unused_ir;

   assign w_unused_ir = ^IR[26:0];

`ifdef CS_MEM_WAIT_EN
   assign w_t1_done = mem_ready;
`else
   assign w_t1_done = 1'b1;
`endif

   opcode_decoder u_opcode_decoder (
      .i_opcode   (IR[31:27]),
      .o_op_class (w_op_class),
      .o_alu_op   (w_dec_alu_op)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_RST;
      end else begin
         case (r_state)
            ST_RST:  r_state <= ST_T0;
            ST_T0:   r_state <= ST_T1;
            ST_T1:   r_state <= w_t1_done ? ST_T2 : ST_T1;
            ST_T2:   r_state <= ST_T3;
            ST_T3: begin
               case (w_op_class)
                  OPC_ALU:  r_state <= ST_T4;
                  OPC_HALT: r_state <= ST_HALT;
                  default:  r_state <= Stop ? ST_HALT : ST_T0;
               endcase
            end
            ST_T4:   r_state <= ST_T5;
            ST_T5:   r_state <= Stop ? ST_HALT : ST_T0;
            ST_HALT: r_state <= ST_HALT;
            default: r_state <= ST_RST;
         endcase
      end
   end

   // Outputs decode the state register directly: IR is loaded on the edge that
   // enters T3, so T3/T4 strobes must see the new IR rather than a stale copy.
   always_comb begin
      ctrl   = '0;
      alu_op = ALU_NONE;
      Run    = 1'b0;
      case (r_state)
         ST_T0: begin ctrl = CTRL_T0; Run = 1'b1; end
         ST_T1: begin ctrl = CTRL_T1; Run = 1'b1; end
         ST_T2: begin ctrl = CTRL_T2; Run = 1'b1; end
         ST_T3: begin
            Run = 1'b1;
            if (w_op_class == OPC_ALU)
               ctrl = CTRL_T3;
         end
         ST_T4: begin ctrl = CTRL_T4; alu_op = w_dec_alu_op; Run = 1'b1; end
         ST_T5: begin ctrl = CTRL_T5; Run = 1'b1; end
         default: ;
      endcase
   end

   assign state = r_state;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer (optionally CS_MEM_WAIT_EN).
`timescale 1ns/1ps
module tb_control_sequencer;

   logic        clock;
   logic        reset;
   logic [31:0] IR;
   logic        Stop;
   logic        mem_ready;
   logic [15:0] ctrl;
   logic [3:0]  alu_op;
   logic        Run;
   logic [3:0]  state;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [31:0] IR_AND  = 32'h28918000;
   localparam logic [31:0] IR_ADD  = 32'h18918000;
   localparam logic [31:0] IR_OR   = 32'h30918000;
   localparam logic [31:0] IR_HALT = 32'hD8000000;
   localparam logic [31:0] IR_NOP  = 32'hF8000000;

   // Hand-computed strobe words for each step
   localparam logic [15:0] C_T0 = 16'h0219;
   localparam logic [15:0] C_T1 = 16'h0462;
   localparam logic [15:0] C_T2 = 16'h0084;
   localparam logic [15:0] C_T3 = 16'h9100;
   localparam logic [15:0] C_T4 = 16'hA010;
   localparam logic [15:0] C_T5 = 16'h4802;

   control_sequencer dut (
      .clock     (clock),
      .reset     (reset),
      .IR        (IR),
      .Stop      (Stop),
`ifdef CS_MEM_WAIT_EN
      .mem_ready (mem_ready),
`endif
      .ctrl      (ctrl),
      .alu_op    (alu_op),
      .Run       (Run),
      .state     (state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [3:0]  exp_state [6];
   logic [15:0] exp_ctrl  [6];
   initial begin
      exp_state[0] = 4'd7;  exp_ctrl[0] = C_T0;
      exp_state[1] = 4'd8;  exp_ctrl[1] = C_T1;
      exp_state[2] = 4'd9;  exp_ctrl[2] = C_T2;
      exp_state[3] = 4'd10; exp_ctrl[3] = C_T3;
      exp_state[4] = 4'd11; exp_ctrl[4] = C_T4;
      exp_state[5] = 4'd12; exp_ctrl[5] = C_T5;
   end

   // Pulse reset across one clock; returns at a negedge with state in RST.
   task automatic do_reset(input logic [31:0] ir);
      @(negedge clock);
      IR = ir;
      Stop = 1'b0;
      mem_ready = 1'b1;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clock);
      n_tests++;
      if (state !== 4'd0 || ctrl !== 16'h0 || alu_op !== 4'd0 || Run !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: state=%0d ctrl=%h alu=%0d run=%b, want 0/0000/0/0",
                  state, ctrl, alu_op, Run);
      end
      do_reset(IR_AND);
      @(negedge clock);
      n_tests++;
      if (state !== 4'd7 || ctrl !== C_T0 || Run !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release: state=%0d ctrl=%h run=%b, want 7/%h/1", state, ctrl, Run, C_T0);
      end
      $display("[TB] reset: released into T0");
   endtask

   task automatic test_and();
      logic [3:0] ea;
      do_reset(IR_AND);
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         ea = (i == 4) ? 4'd3 : 4'd0;
         n_tests++;
         if (state !== exp_state[i] || ctrl !== exp_ctrl[i] || alu_op !== ea || Run !== 1'b1) begin
            n_fail++;
            $display("FAIL and_step%0d: state=%0d ctrl=%h alu=%0d run=%b, want %0d/%h/%0d/1",
                     i, state, ctrl, alu_op, Run, exp_state[i], exp_ctrl[i], ea);
         end
      end
      @(negedge clock);
      n_tests++;
      if (state !== 4'd7 || ctrl !== C_T0) begin
         n_fail++;
         $display("FAIL and_wrap: state=%0d ctrl=%h, want 7/%h", state, ctrl, C_T0);
      end
      $display("[TB] and: T0..T5 then T0");
   endtask

   task automatic test_alu_ops();
      logic [31:0] irs [2];
      logic [3:0]  ops [2];
      logic [3:0]  ea;
      irs[0] = IR_ADD; ops[0] = 4'd1;
      irs[1] = IR_OR;  ops[1] = 4'd4;
      for (int k = 0; k < 2; k++) begin
         do_reset(irs[k]);
         for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            ea = (i == 4) ? ops[k] : 4'd0;
            n_tests++;
            if (alu_op !== ea || state !== exp_state[i]) begin
               n_fail++;
               $display("FAIL aluop_ir%h_step%0d: alu=%0d state=%0d, want %0d/%0d",
                        irs[k], i, alu_op, state, ea, exp_state[i]);
            end
         end
         $display("[TB] alu_ops: IR=%h alu_op=%0d in T4 only", irs[k], ops[k]);
      end
   endtask

   task automatic test_halt();
      do_reset(IR_HALT);
      repeat (4) @(negedge clock);
      n_tests++;
      if (state !== 4'd10 || ctrl !== 16'h0 || Run !== 1'b1) begin
         n_fail++;
         $display("FAIL halt_t3: state=%0d ctrl=%h run=%b, want 10/0000/1", state, ctrl, Run);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         n_tests++;
         if (state !== 4'd15 || ctrl !== 16'h0 || Run !== 1'b0 || alu_op !== 4'd0) begin
            n_fail++;
            $display("FAIL halt_hold%0d: state=%0d ctrl=%h run=%b alu=%0d, want 15/0000/0/0",
                     i, state, ctrl, Run, alu_op);
         end
         Stop = ~Stop;
      end
      Stop = 1'b0;
      $display("[TB] halt: held HALT for 10 cycles with Stop toggling");
   endtask

   task automatic test_stop();
      do_reset(IR_AND);
      repeat (5) @(negedge clock);
      Stop = 1'b1;
      @(negedge clock);
      n_tests++;
      if (state !== 4'd12 || ctrl !== C_T5) begin
         n_fail++;
         $display("FAIL stop_t5: state=%0d ctrl=%h, want 12/%h", state, ctrl, C_T5);
      end
      @(negedge clock);
      n_tests++;
      if (state !== 4'd15 || Run !== 1'b0) begin
         n_fail++;
         $display("FAIL stop_halt: state=%0d run=%b, want 15/0", state, Run);
      end
      Stop = 1'b0;
      @(negedge clock);
      n_tests++;
      if (state !== 4'd15) begin
         n_fail++;
         $display("FAIL stop_release: state=%0d, want 15", state);
      end
      $display("[TB] stop: T5 completed then HALT");
   endtask

   task automatic test_nop();
      do_reset(IR_NOP);
      repeat (4) @(negedge clock);
      n_tests++;
      if (state !== 4'd10 || ctrl !== 16'h0 || alu_op !== 4'd0) begin
         n_fail++;
         $display("FAIL nop_t3: state=%0d ctrl=%h alu=%0d, want 10/0000/0", state, ctrl, alu_op);
      end
      @(negedge clock);
      n_tests++;
      if (state !== 4'd7) begin
         n_fail++;
         $display("FAIL nop_wrap: state=%0d, want 7", state);
      end
      repeat (3) @(negedge clock);
      Stop = 1'b1;
      @(negedge clock);
      n_tests++;
      if (state !== 4'd15) begin
         n_fail++;
         $display("FAIL nop_stop: state=%0d, want 15", state);
      end
      Stop = 1'b0;
      $display("[TB] nop: T3 -> T0, and T3 -> HALT with Stop");
   endtask

   task automatic test_async_reset();
      do_reset(IR_AND);
      repeat (5) @(negedge clock);
      n_tests++;
      if (state !== 4'd11 || ctrl !== C_T4) begin
         n_fail++;
         $display("FAIL areset_pre: state=%0d ctrl=%h, want 11/%h", state, ctrl, C_T4);
      end
      #1 reset = 1'b1;
      #1;
      n_tests++;
      if (state !== 4'd0 || ctrl !== 16'h0 || alu_op !== 4'd0 || Run !== 1'b0) begin
         n_fail++;
         $display("FAIL areset_clear: state=%0d ctrl=%h alu=%0d run=%b, want 0/0000/0/0",
                  state, ctrl, alu_op, Run);
      end
      #2 reset = 1'b0;
      @(negedge clock);
      n_tests++;
      if (state !== 4'd7 || ctrl !== C_T0) begin
         n_fail++;
         $display("FAIL areset_restart: state=%0d ctrl=%h, want 7/%h", state, ctrl, C_T0);
      end
      $display("[TB] async_reset: cleared mid-T4, restarted at T0");
   endtask

`ifdef CS_MEM_WAIT_EN
   task automatic test_mem_wait();
      do_reset(IR_AND);
      @(negedge clock);
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         n_tests++;
         if (state !== 4'd8 || ctrl !== C_T1) begin
            n_fail++;
            $display("FAIL memwait_t1_%0d: state=%0d ctrl=%h, want 8/%h", i, state, ctrl, C_T1);
         end
      end
      mem_ready = 1'b1;
      @(negedge clock);
      n_tests++;
      if (state !== 4'd9 || ctrl !== C_T2) begin
         n_fail++;
         $display("FAIL memwait_t2: state=%0d ctrl=%h, want 9/%h", state, ctrl, C_T2);
      end
      $display("[TB] mem_wait: T1 held 4 cycles then T2");
   endtask
`endif

   initial begin
      reset     = 1'b1;
      IR        = 32'h0;
      Stop      = 1'b0;
      mem_ready = 1'b1;
      test_reset();
      test_and();
      test_alu_ops();
      test_halt();
      test_stop();
      test_nop();
      test_async_reset();
`ifdef CS_MEM_WAIT_EN
      test_mem_wait();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
